// File: rtl/ahb_pkg.sv
// Shared AHB encodings and arbiter definitions.
// Used by the bus arbiter and its round-robin picker.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_t;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'd0,
      HBURST_INCR   = 3'd1,
      HBURST_WRAP4  = 3'd2,
      HBURST_INCR4  = 3'd3,
      HBURST_WRAP8  = 3'd4,
      HBURST_INCR8  = 3'd5,
      HBURST_WRAP16 = 3'd6,
      HBURST_INCR16 = 3'd7
   } hburst_t;

   typedef logic [1:0] arb_state_t;
   localparam arb_state_t ST_ARB    = 2'd0;
   localparam arb_state_t ST_BURST  = 2'd1;
   localparam arb_state_t ST_LOCKED = 2'd2;

   // Beat count of a burst; 0 marks the undefined-length INCR.
   function automatic logic [4:0] burst_len(input logic [2:0] hburst);
      case (hburst)
         HBURST_SINGLE:               burst_len = 5'd1;
         HBURST_INCR:                 burst_len = 5'd0;
         HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
         HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
         HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
         default:                     burst_len = 5'd1;
      endcase
   endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin search: first requester after last_owner, wrapping.
// Emits a one-hot pick and a valid flag; reusable by any arbiter.
module ahb_rr_picker #(
   parameter int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last_owner,
   output logic [N-1:0] pick,
   output logic         valid
);

   logic [W-1:0] idx;

   // Walk indices last_owner+1 .. last_owner+N; the first hit wins.
   always_comb begin
      pick  = {N{1'b0}};
      valid = 1'b0;
      idx   = {W{1'b0}};
      for (int i = 1; i <= N; i++) begin
         idx = W'((int'(last_owner) + i) % N);
         if (!valid && req[idx]) begin
            pick[idx] = 1'b1;
            valid     = 1'b1;
         end else begin
            valid = valid;
         end
      end
   end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with fixed-length burst and locked-transfer support.
// Parks on DEFAULT_MASTER when idle; drives HMASTER, data-phase owner and HMASTLOCK.
module ahb_arbiter
   import ahb_pkg::*;
#(
   parameter int MASTER_DEVICES = 4,
   parameter int DEFAULT_MASTER = 0,
   localparam int MW = $clog2(MASTER_DEVICES)
) (
   input  logic                      ahb_clk_in,
   input  logic                      ahb_rst_in,
   input  logic [MASTER_DEVICES-1:0] busreq_in,
   input  logic [MASTER_DEVICES-1:0] lock_in,
   input  logic [1:0]                htrans_in,
   input  logic [2:0]                hburst_in,
   input  logic                      ahb_ready_in,
   output logic [MASTER_DEVICES-1:0] grant_out,
   output logic [MW-1:0]             master_out,
   output logic [MW-1:0]             master_data_out,
   output logic                      mastlock_out
);

   localparam logic [MASTER_DEVICES-1:0] PARK_GRANT =
      {{(MASTER_DEVICES-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
   localparam logic [MW-1:0] PARK_IDX = MW'(DEFAULT_MASTER);

   arb_state_t                state;
   arb_state_t                state_nxt;
   logic [3:0]                beat_cnt;
   logic [3:0]                beat_nxt;
   logic [MW-1:0]             last_owner;
   logic [MW-1:0]             last_nxt;
   logic [MASTER_DEVICES-1:0] grant_nxt;
   logic [MASTER_DEVICES-1:0] pick;
   logic                      pick_valid;
   logic [MW-1:0]             pick_idx;
   logic [MW-1:0]             owner_idx;
   logic [4:0]                blen;
   logic                      rearb;

   ahb_rr_picker #(.N(MASTER_DEVICES)) u_picker (
      .req        (busreq_in),
      .last_owner (last_owner),
      .pick       (pick),
      .valid      (pick_valid)
   );

   // One-hot to index for the current grant and the picker result.
   always_comb begin
      owner_idx = {MW{1'b0}};
      pick_idx  = {MW{1'b0}};
      for (int i = 0; i < MASTER_DEVICES; i++) begin
         owner_idx = owner_idx | (grant_out[i] ? MW'(i) : {MW{1'b0}});
         pick_idx  = pick_idx  | (pick[i]      ? MW'(i) : {MW{1'b0}});
      end
   end

   assign blen = burst_len(hburst_in);

   // Next-state decision; applied only on edges where the bus is ready.
   always_comb begin
      state_nxt = state;
      beat_nxt  = beat_cnt;
      grant_nxt = grant_out;
      last_nxt  = last_owner;
      rearb     = 1'b0;
      case (state)
         ST_ARB: begin
            if (lock_in[owner_idx] && busreq_in[owner_idx]) begin
               state_nxt = ST_LOCKED;
            end else if ((htrans_in == HTRANS_NONSEQ) && (blen >= 5'd4)) begin
               state_nxt = ST_BURST;
               beat_nxt  = 4'(blen - 5'd1);
            end else begin
               rearb = 1'b1;
            end
         end
         ST_BURST: begin
            case (htrans_in)
               HTRANS_SEQ: begin
                  if (beat_cnt <= 4'd1) begin
                     rearb     = 1'b1;
                     state_nxt = ST_ARB;
                     beat_nxt  = 4'd0;
                  end else begin
                     beat_nxt = beat_cnt - 4'd1;
                  end
               end
               HTRANS_BUSY: beat_nxt = beat_cnt;
               default: begin
                  rearb     = 1'b1;
                  state_nxt = ST_ARB;
               end
            endcase
         end
         ST_LOCKED: begin
            if (!lock_in[owner_idx]) begin
               rearb     = 1'b1;
               state_nxt = ST_ARB;
            end else begin
               state_nxt = ST_LOCKED;
            end
         end
         default: begin
            rearb     = 1'b1;
            state_nxt = ST_ARB;
         end
      endcase
      // Parking on the default master leaves the rotation pointer alone.
      if (rearb) begin
         if (pick_valid) begin
            grant_nxt = pick;
            last_nxt  = pick_idx;
         end else begin
            grant_nxt = PARK_GRANT;
         end
      end else begin
         grant_nxt = grant_out;
      end
   end

   // Arbiter state and outputs; a low ready freezes everything.
   always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
      if (ahb_rst_in) begin
         state           <= ST_ARB;
         beat_cnt        <= 4'd0;
         last_owner      <= PARK_IDX;
         grant_out       <= PARK_GRANT;
         master_out      <= PARK_IDX;
         master_data_out <= PARK_IDX;
         mastlock_out    <= 1'b0;
      end else if (ahb_ready_in) begin
         state           <= state_nxt;
         beat_cnt        <= beat_nxt;
         last_owner      <= last_nxt;
         grant_out       <= grant_nxt;
         master_out      <= owner_idx;
         master_data_out <= master_out;
         mastlock_out    <= lock_in[owner_idx];
      end
   end

endmodule
